// File: rtl/fill_seq_ctrl_pkg.sv
// fill_pkg: shared state codes, digit-select codes, counter control encodings and BCD helper
// for the fill sequencer. No ports; imported by fill_seq_ctrl.
package fill_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CLEAR = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        FULL  = 3'd5
    } state_t;
    localparam logic [1:0] SEL_MAXL = 2'd0;
    localparam logic [1:0] SEL_MAXH = 2'd1;
    localparam logic [1:0] SEL_BOTL = 2'd2;
    localparam logic [1:0] SEL_BOTH = 2'd3;
    // {EN_work, EN_set} as seen by the counter
    localparam logic [1:0] CTL_CLEAR  = 2'b11;
    localparam logic [1:0] CTL_SETUP  = 2'b01;
    localparam logic [1:0] CTL_HOLD   = 2'b10;
    localparam logic [1:0] CTL_STROBE = 2'b00;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction
endpackage

// File: rtl/fill_seq_ctrl_if.sv
// fill_seq_ctrl_if: panel-button, counter-status and control/target bundle of the fill sequencer.
// master drives buttons, set_sel and cnt_full; slave (the sequencer) drives the counter controls,
// BCD targets, feed_tick, cfg_err, alarm and state.
interface fill_seq_ctrl_if;
    logic       btn_set, btn_inc, btn_start, btn_stop, btn_conti, btn_clear;
    logic [1:0] set_sel;
    logic       cnt_full;
    logic       isWork, EN_work, EN_set, conti_p, feed_tick, cfg_err, alarm;
    logic [3:0] maxL, maxH, bot_maxL, bot_maxH;
    logic [2:0] state;
    modport master (
        output btn_set, btn_inc, btn_start, btn_stop, btn_conti, btn_clear, set_sel, cnt_full,
        input  isWork, EN_work, EN_set, conti_p, feed_tick, cfg_err, alarm,
               maxL, maxH, bot_maxL, bot_maxH, state
    );
    modport slave (
        input  btn_set, btn_inc, btn_start, btn_stop, btn_conti, btn_clear, set_sel, cnt_full,
        output isWork, EN_work, EN_set, conti_p, feed_tick, cfg_err, alarm,
               maxL, maxH, bot_maxL, bot_maxH, state
    );
endinterface

// File: rtl/fill_seq_ctrl_key_edge.sv
// key_edge: rising-edge detector for one debounced button level.
// Ports: CLK, RST (async, active-high), i_in button level, o_edge = i_in & ~previous level.
module key_edge (
    input  logic CLK,
    input  logic RST,
    input  logic i_in,
    output logic o_edge
);
    logic r_prev;
    always_ff @(posedge CLK or posedge RST)
        if (RST) r_prev <= 1'b0;
        else     r_prev <= i_in;
    assign o_edge = i_in & ~r_prev;
endmodule

// File: rtl/fill_seq_ctrl.sv
// fill_seq_ctrl: mode sequencer for the pill counter; holds and edits the BCD fill targets and
// drives isWork/EN_work/EN_set/conti_p plus the paced count strobe.
// Ports: CLK, RST (async, active-high), bus (fill_seq_ctrl_if.slave: buttons, set_sel, cnt_full in;
// counter controls, targets, feed_tick, cfg_err, alarm, state out). All outputs come from registers.
module fill_seq_ctrl
    import fill_pkg::*;
#(
    parameter int         FEED_DIV = 25,
    parameter logic [3:0] DEF_MAXL = 4'd5,
    parameter logic [3:0] DEF_MAXH = 4'd0,
    parameter logic [3:0] DEF_BOTL = 4'd3,
    parameter logic [3:0] DEF_BOTH = 4'd0
) (
    input logic            CLK,
    input logic            RST,
    fill_seq_ctrl_if.slave bus
);
    localparam int            DW     = $clog2(FEED_DIV);
    localparam logic [DW-1:0] DIV_TC = DW'(FEED_DIV - 1);
    state_t        r_state, r_ret, w_next, w_ret;
    logic [DW-1:0] r_div;
    logic [3:0]    r_maxl, r_maxh, r_botl, r_both;
    logic          r_strobe, r_conti, r_err, r_full_prev;
    logic          w_err, w_conti, w_div_clr, w_inc, w_stay, w_term, w_valid, w_full_rise;
    logic [5:0]    w_edge, w_win;
    logic          w_clr, w_stop, w_start, w_cont, w_set, w_incb;
    key_edge u_clear (.CLK(CLK), .RST(RST), .i_in(bus.btn_clear), .o_edge(w_edge[0]));
    key_edge u_stop  (.CLK(CLK), .RST(RST), .i_in(bus.btn_stop),  .o_edge(w_edge[1]));
    key_edge u_start (.CLK(CLK), .RST(RST), .i_in(bus.btn_start), .o_edge(w_edge[2]));
    key_edge u_conti (.CLK(CLK), .RST(RST), .i_in(bus.btn_conti), .o_edge(w_edge[3]));
    key_edge u_set   (.CLK(CLK), .RST(RST), .i_in(bus.btn_set),   .o_edge(w_edge[4]));
    key_edge u_inc   (.CLK(CLK), .RST(RST), .i_in(bus.btn_inc),   .o_edge(w_edge[5]));
    // Only the highest-priority coincident edge acts: isolate the lowest set bit (bit 0 = clear).
    assign w_win = w_edge & (~w_edge + 6'd1);
    assign {w_incb, w_set, w_cont, w_start, w_stop, w_clr} = w_win;
    assign w_full_rise = bus.cnt_full & ~r_full_prev;
    assign w_valid     = (r_maxl != 4'd0) && (r_maxl <= BCD_MAX) && ({r_both, r_botl} != 8'h00);
    assign w_term      = (r_div == DIV_TC);
    assign w_stay      = (r_state == RUN) && (w_next == RUN);
    always_comb begin
        w_next    = r_state;
        w_ret     = r_ret;
        w_err     = r_err;
        w_conti   = 1'b0;
        w_div_clr = 1'b0;
        w_inc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clr) begin
                    w_next = CLEAR;
                    w_ret  = IDLE;
                end else if (w_start) begin
                    w_err = ~w_valid;
                    if (w_valid) begin
                        w_next = CLEAR;
                        w_ret  = RUN;
                    end
                end else if (w_set) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_next = w_set ? IDLE : SETUP;
                w_inc  = w_incb;
            end
            CLEAR: begin
                w_next    = r_ret;
                w_div_clr = 1'b1;
            end
            RUN: begin
                // a counter-full rise outranks a stop in the same cycle
                w_next = w_full_rise ? FULL : w_stop ? PAUSE : RUN;
            end
            PAUSE: begin
                if (w_clr) begin
                    w_next = CLEAR;
                    w_ret  = IDLE;
                end else if (w_stop) begin
                    w_next = IDLE;
                end else if (w_start) begin
                    w_next = RUN;
                end
            end
            FULL: begin
                if (w_clr) begin
                    w_next = CLEAR;
                    w_ret  = IDLE;
                end else if (w_stop) begin
                    w_next = IDLE;
                end else if (w_cont) begin
                    w_next    = RUN;
                    w_conti   = 1'b1;
                    w_div_clr = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_ret       <= IDLE;
            r_div       <= '0;
            r_strobe    <= 1'b0;
            r_conti     <= 1'b0;
            r_err       <= 1'b0;
            r_full_prev <= 1'b0;
            r_maxl      <= DEF_MAXL;
            r_maxh      <= DEF_MAXH;
            r_botl      <= DEF_BOTL;
            r_both      <= DEF_BOTH;
        end else begin
            r_state     <= w_next;
            r_ret       <= w_ret;
            r_conti     <= w_conti;
            r_err       <= w_err;
            r_full_prev <= bus.cnt_full;
            // the divider only advances while RUN continues, so a pause freezes it and a
            // terminal count seen on the way out of RUN never turns into a strobe
            r_div       <= w_div_clr ? '0 : w_stay ? (w_term ? '0 : r_div + 1'b1) : r_div;
            r_strobe    <= w_stay && w_term;
            r_maxl      <= (w_inc && bus.set_sel == SEL_MAXL) ? bcd_inc(r_maxl) : r_maxl;
            r_maxh      <= (w_inc && bus.set_sel == SEL_MAXH) ? bcd_inc(r_maxh) : r_maxh;
            r_botl      <= (w_inc && bus.set_sel == SEL_BOTL) ? bcd_inc(r_botl) : r_botl;
            r_both      <= (w_inc && bus.set_sel == SEL_BOTH) ? bcd_inc(r_both) : r_both;
        end
    end
    assign bus.isWork    = (r_state == RUN) || (r_state == PAUSE) || (r_state == FULL);
    assign {bus.EN_work, bus.EN_set} = (r_state == CLEAR) ? CTL_CLEAR :
                                       (r_state == SETUP) ? CTL_SETUP :
                                       r_strobe           ? CTL_STROBE : CTL_HOLD;
    assign bus.feed_tick = r_strobe;
    assign bus.conti_p   = r_conti;
    assign bus.cfg_err   = r_err;
    assign bus.alarm     = (r_state == FULL);
    assign bus.state     = r_state;
    assign bus.maxL      = r_maxl;
    assign bus.maxH      = r_maxh;
    assign bus.bot_maxL  = r_botl;
    assign bus.bot_maxH  = r_both;
endmodule

// File: tb/tb_fill_seq_ctrl.sv
// tb_fill_seq_ctrl: directed plus randomized bench for fill_seq_ctrl against a behavioural model.
module tb_fill_seq_ctrl;
    localparam int FD = 4;
    localparam int B_CLR = 0, B_STOP = 1, B_START = 2, B_CONTI = 3, B_SET = 4, B_INC = 5;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] btn = '0;
    logic [1:0] sel = '0;
    logic       full = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;
    int         n, nt;
    fill_seq_ctrl_if bus ();
    assign bus.btn_clear = btn[B_CLR];
    assign bus.btn_stop  = btn[B_STOP];
    assign bus.btn_start = btn[B_START];
    assign bus.btn_conti = btn[B_CONTI];
    assign bus.btn_set   = btn[B_SET];
    assign bus.btn_inc   = btn[B_INC];
    assign bus.set_sel   = sel;
    assign bus.cnt_full  = full;
    fill_seq_ctrl #(.FEED_DIV(FD)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    wire [6:0]  w_ctl = {bus.isWork, bus.EN_work, bus.EN_set, bus.feed_tick, bus.conti_p, bus.alarm, bus.cfg_err};
    wire [15:0] w_tgt = {bus.maxL, bus.maxH, bus.bot_maxL, bus.bot_maxH};
    // model: mode numbers are the published state codes; m_n counts divider advances since
    // the last divider reset, a strobe follows every FD-th advance
    int         m_mode, m_ret, m_n;
    int         m_tgt [4];
    bit         m_err, m_conti, m_strobe, m_fprev;
    logic [5:0] m_prev;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_mode = 0; m_ret = 0; m_n = 0;
        m_tgt = '{5, 0, 3, 0};
        m_err = 0; m_conti = 0; m_strobe = 0; m_fprev = 0; m_prev = '0;
    endtask
    task automatic model_step();
        logic [5:0] ed;
        int         win, nm;
        bit         fr, stay, rdiv, valid;
        ed     = btn & ~m_prev;
        m_prev = btn;
        fr      = full && !m_fprev;
        m_fprev = full;
        win = -1;
        for (int i = 5; i >= 0; i--) if (ed[i]) win = i;
        valid   = m_tgt[0] >= 1 && m_tgt[0] <= 9 && (m_tgt[2] + m_tgt[3]) != 0;
        nm      = m_mode;
        m_conti = 0;
        rdiv    = 0;
        case (m_mode)
            0: begin
                if (win == B_CLR) begin nm = 2; m_ret = 0; end
                else if (win == B_START) begin
                    m_err = !valid;
                    if (valid) begin nm = 2; m_ret = 3; end
                end else if (win == B_SET) nm = 1;
            end
            1: begin
                if (win == B_SET) nm = 0;
                else if (win == B_INC) m_tgt[sel] = (m_tgt[sel] + 1) % 10;
            end
            2: begin nm = m_ret; rdiv = 1; end
            3: begin
                if (fr) nm = 5;
                else if (win == B_STOP) nm = 4;
            end
            4: begin
                if (win == B_CLR) begin nm = 2; m_ret = 0; end
                else if (win == B_STOP) nm = 0;
                else if (win == B_START) nm = 3;
            end
            5: begin
                if (win == B_CLR) begin nm = 2; m_ret = 0; end
                else if (win == B_STOP) nm = 0;
                else if (win == B_CONTI) begin nm = 3; m_conti = 1; rdiv = 1; end
            end
            default: nm = 0;
        endcase
        stay     = m_mode == 3 && nm == 3;
        m_strobe = stay && (m_n % FD == FD - 1);
        if (stay) m_n++;
        if (rdiv) m_n = 0;
        m_mode = nm;
    endtask
    task automatic cmp_model();
        logic [1:0] en;
        logic [6:0] ctl;
        en  = (m_mode == 2) ? 2'b11 : (m_mode == 1) ? 2'b01 : m_strobe ? 2'b00 : 2'b10;
        ctl = {m_mode >= 3, en, m_strobe, m_conti, m_mode == 5, m_err};
        chk("m_state", 32'(bus.state), 32'(m_mode));
        chk("m_ctl", 32'(w_ctl), 32'(ctl));
        chk("m_tgt", 32'(w_tgt), 32'((m_tgt[0] << 12) | (m_tgt[1] << 8) | (m_tgt[2] << 4) | m_tgt[3]));
    endtask
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        cmp_model();
    endtask
    task automatic press(input int b);
        btn[b] = 1'b1;
        tick();
        btn = '0;
        tick();
    endtask
    task automatic run_until_tick(output int cnt);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.feed_tick) begin
                cnt = i;
                return;
            end
        end
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_ctl"}, 32'(w_ctl), 32'h20);
        chk({tag, "_tgt"}, 32'(w_tgt), 32'h5030);
    endtask
    initial begin
        model_reset();
        #12;
        chk_reset_vals("rst");
        RST = 1'b0;
        btn[B_START] = 1'b1;
        tick();
        chk("clear_pulse", 32'({bus.EN_work, bus.EN_set, bus.state}), 32'({2'b11, 3'd2}));
        btn = '0;
        run_until_tick(n);
        chk("first_strobe_cycle", n, 5);
        chk("strobe_ctl", 32'({bus.EN_work, bus.EN_set, bus.state}), 32'({2'b00, 3'd3}));
        run_until_tick(n);
        chk("strobe_period", n, 4);
        tick();
        tick();
        btn[B_STOP] = 1'b1;
        tick();
        chk("pause_state", 32'(bus.state), 4);
        btn = '0;
        nt = 0;
        repeat (6) begin
            tick();
            nt += int'(bus.feed_tick);
        end
        chk("pause_no_strobe", nt, 0);
        btn[B_START] = 1'b1;
        tick();
        btn = '0;
        run_until_tick(n);
        chk("resume_remaining", n, 2);
        full = 1'b1;
        btn[B_STOP] = 1'b1;
        tick();
        chk("full_beats_stop", 32'({bus.state, bus.alarm, bus.isWork}), 32'({3'd5, 2'b11}));
        btn = '0;
        full = 1'b0;
        tick();
        btn[B_CONTI] = 1'b1;
        tick();
        chk("conti_pulse", 32'({bus.conti_p, bus.state}), 32'({1'b1, 3'd3}));
        btn = '0;
        run_until_tick(n);
        chk("conti_strobe_cycle", n + 1, 5);
        press(B_STOP);
        press(B_STOP);
        chk("idle_after_stops", 32'(bus.state), 0);
        btn[B_START] = 1'b1;
        btn[B_CLR] = 1'b1;
        tick();
        chk("clear_wins", 32'(bus.state), 2);
        btn = '0;
        tick();
        chk("clear_to_idle", 32'({bus.state, bus.isWork}), 32'({3'd0, 1'b0}));
        press(B_SET);
        chk("setup_ctl", 32'({bus.state, bus.EN_work, bus.EN_set}), 32'({3'd1, 2'b01}));
        sel = 2'd0;
        for (int k = 0; k < 10; k++) begin
            press(B_INC);
            chk("inc_maxl", 32'(bus.maxL), (6 + k) % 10);
        end
        repeat (5) press(B_INC);
        chk("maxl_zero", 32'(bus.maxL), 0);
        press(B_SET);
        btn[B_START] = 1'b1;
        tick();
        chk("cfg_err", 32'({bus.cfg_err, bus.state, bus.EN_work, bus.EN_set}), 32'({1'b1, 3'd0, 2'b10}));
        btn = '0;
        tick();
        chk("cfg_err_stay", 32'(bus.state), 0);
        press(B_SET);
        press(B_INC);
        press(B_SET);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 6; b++) if ($urandom_range(7) == 0) btn[b] = ~btn[b];
            if ($urandom_range(3) == 0) sel = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) full = ~full;
            tick();
        end
        btn = '0;
        full = 1'b0;
        RST = 1'b1;
        model_reset();
        #4;
        RST = 1'b0;
        btn[B_START] = 1'b1;
        tick();
        btn = '0;
        run_until_tick(n);
        chk("strobe_before_rst", n, 5);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        #3;
        RST = 1'b0;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
